// File: rtl/dst_gen.sv
// rtl/dst_gen.sv - display scan-timing generator with pixel enable, sync polarity and output delay
`timescale 1ns/1ps
module dst_gen #(
  parameter int H_SW   = 120,
  parameter int H_BP   = 64,
  parameter int H_ACT  = 800,
  parameter int H_FP   = 56,
  parameter int V_SW   = 6,
  parameter int V_BP   = 23,
  parameter int V_ACT  = 600,
  parameter int V_FP   = 37,
  parameter int HS_POL = 1,
  parameter int VS_POL = 1,
  parameter int DELAY  = 0,
  parameter int CW     = 12
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          pce,
  output logic          hs,
  output logic          vs,
  output logic          hen,
  output logic          ven,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SW + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SW + V_BP + V_ACT + V_FP;

  // Refuse to build a timing that the counters cannot represent.
  if (H_TOTAL > (1 << CW)) begin : g_h_total_chk
    $error("dst_gen: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > (1 << CW)) begin : g_v_total_chk
    $error("dst_gen: V_TOTAL exceeds counter range");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_delay_chk
    $error("dst_gen: DELAY must be 0..15");
  end

  // Region boundaries are one bit wider than the counters so an active region
  // ending exactly at 2^CW (zero front porch) still compares correctly.
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW:0]   H_SYNC  = (CW+1)'(H_SW);
  localparam logic [CW:0]   V_SYNC  = (CW+1)'(V_SW);
  localparam logic [CW:0]   H_ACT_S = (CW+1)'(H_SW + H_BP);
  localparam logic [CW:0]   H_ACT_E = (CW+1)'(H_SW + H_BP + H_ACT);
  localparam logic [CW:0]   V_ACT_S = (CW+1)'(V_SW + V_BP);
  localparam logic [CW:0]   V_ACT_E = (CW+1)'(V_SW + V_BP + V_ACT);
  localparam logic [CW-1:0] H_OFS   = CW'(H_SW + H_BP);
  localparam logic [CW-1:0] V_OFS   = CW'(V_SW + V_BP);
  localparam logic          HS_HI   = (HS_POL != 0);
  localparam logic          VS_HI   = (VS_POL != 0);

  // One pipeline word; sync bits are kept raw and polarity is applied at the output
  // so an all-zero reset word reads as inactive sync for either polarity.
  typedef struct packed {
    logic          hs_a;
    logic          vs_a;
    logic          hen;
    logic          ven;
    logic          de;
    logic          ls;
    logic          fs;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } stage_t;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_hen;
  logic          w_ven;
  stage_t        w_dec;
  stage_t        r_pipe [0:DELAY];
  stage_t        w_out;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  // Scan counters: h advances on every enabled pixel, v on the last pixel of a line.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (pce) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CW'(1);
      end
    end
  end

  assign w_hen = ({1'b0, r_h_cnt} >= H_ACT_S) && ({1'b0, r_h_cnt} < H_ACT_E);
  assign w_ven = ({1'b0, r_v_cnt} >= V_ACT_S) && ({1'b0, r_v_cnt} < V_ACT_E);

  // Stage-0 decode of the current counter position.
  always_comb begin
    w_dec      = '0;
    w_dec.hs_a = ({1'b0, r_h_cnt} < H_SYNC);
    w_dec.vs_a = ({1'b0, r_v_cnt} < V_SYNC);
    w_dec.hen  = w_hen;
    w_dec.ven  = w_ven;
    w_dec.de   = w_hen & w_ven;
    w_dec.x    = w_hen ? (r_h_cnt - H_OFS) : '0;
    w_dec.y    = w_ven ? (r_v_cnt - V_OFS) : '0;
    w_dec.ls   = pce & (r_h_cnt == '0);
    w_dec.fs   = pce & (r_h_cnt == '0) & (r_v_cnt == '0);
  end

  // Output pipeline: free-running (not gated by pce) so pulses last one pclk.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DELAY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_dec;
      for (int i = 1; i <= DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_out       = r_pipe[DELAY];
  assign hs          = HS_HI ? w_out.hs_a : ~w_out.hs_a;
  assign vs          = VS_HI ? w_out.vs_a : ~w_out.vs_a;
  assign hen         = w_out.hen;
  assign ven         = w_out.ven;
  assign de          = w_out.de;
  assign x           = w_out.x;
  assign y           = w_out.y;
  assign line_start  = w_out.ls;
  assign frame_start = w_out.fs;

endmodule

// File: tb/tb_dst_gen.sv
// tb/tb_dst_gen.sv - self-checking bench for dst_gen
`timescale 1ns/1ps
module tb_dst_gen;

  localparam int H_SW = 3, H_BP = 2, H_ACT = 8, H_FP = 2;
  localparam int V_SW = 2, V_BP = 1, V_ACT = 4, V_FP = 2;
  localparam int HT = H_SW + H_BP + H_ACT + H_FP;
  localparam int VT = V_SW + V_BP + V_ACT + V_FP;
  localparam int CW = 8;
  localparam int D1 = 3;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic          pce  = 1'b0;

  logic          hs0, vs0, hen0, ven0, de0, ls0, fs0;
  logic [CW-1:0] x0, y0;
  logic          hs1, vs1, hen1, ven1, de1, ls1, fs1;
  logic [CW-1:0] x1, y1;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  logic [22:0] hist[$];

  always #5 pclk = ~pclk;

  dst_gen #(
    .H_SW(H_SW), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SW(V_SW), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .HS_POL(1), .VS_POL(1), .DELAY(0), .CW(CW)
  ) u_dut0 (
    .pclk(pclk), .rst(rst), .pce(pce),
    .hs(hs0), .vs(vs0), .hen(hen0), .ven(ven0), .de(de0),
    .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
  );

  dst_gen #(
    .H_SW(H_SW), .H_BP(H_BP), .H_ACT(H_ACT), .H_FP(H_FP),
    .V_SW(V_SW), .V_BP(V_BP), .V_ACT(V_ACT), .V_FP(V_FP),
    .HS_POL(0), .VS_POL(0), .DELAY(D1), .CW(CW)
  ) u_dut1 (
    .pclk(pclk), .rst(rst), .pce(pce),
    .hs(hs1), .vs(vs1), .hen(hen1), .ven(ven1), .de(de1),
    .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
  );

  wire [22:0] w_pk0 = {hs0, vs0, hen0, ven0, de0, ls0, fs0, x0, y0};
  wire [22:0] w_pk1 = {hs1, vs1, hen1, ven1, de1, ls1, fs1, x1, y1};

  // Reference: n counts enabled pixels since reset; position follows by division.
  function automatic logic [22:0] model_raw(int idx, bit p);
    int   h   = idx % HT;
    int   v   = (idx / HT) % VT;
    bit   ha  = h < H_SW;
    bit   va  = v < V_SW;
    bit   he  = (h >= H_SW + H_BP) && (h < H_SW + H_BP + H_ACT);
    bit   ve  = (v >= V_SW + V_BP) && (v < V_SW + V_BP + V_ACT);
    logic [7:0] xs = he ? 8'(h - (H_SW + H_BP)) : 8'd0;
    logic [7:0] ys = ve ? 8'(v - (V_SW + V_BP)) : 8'd0;
    bit   ls  = p && (h == 0);
    bit   fs  = p && (h == 0) && (v == 0);
    return {ha, va, he, ve, he && ve, ls, fs, xs, ys};
  endfunction

  function automatic logic [22:0] expect_out(int d, bit pol);
    logic [22:0] r = (hist.size() > d) ? hist[d] : 23'd0;
    if (!pol) r[22:21] = ~r[22:21];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit p);
    pce = p;
    @(posedge pclk);
    hist.push_front(model_raw(n, p));
    if (hist.size() > 8) void'(hist.pop_back());
    if (p) n++;
    #1;
    chk("dut0_vs_model", 32'(w_pk0), 32'(expect_out(0, 1'b1)));
    chk("dut1_vs_model", 32'(w_pk1), 32'(expect_out(D1, 1'b0)));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_dut0", 32'(w_pk0), 32'(23'h000000));
    chk("rst_async_dut1", 32'(w_pk1), 32'({2'b11, 21'h0}));
    @(posedge pclk);
    #1;
    chk("rst_hold_dut0", 32'(w_pk0), 32'(23'h000000));
    @(negedge pclk);
    rst = 1'b0;
    hist.delete();
    n = 0;
  endtask

  typedef struct {
    bit p;
    bit hs;
    bit vs;
    bit hen;
    bit ls;
    bit fs;
    int x;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int fs_seen, fs_a, fs_b, c_ls, c_de, c_vs, dens;
    int ls_a, ls_b, ls_cnt, c_hs;
    bit prev_ls, dbl;

    tbl[0]  = '{1, 1, 1, 0, 1, 1, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 1, 1, 0, 0, 1};
    tbl[8]  = '{1, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 1, 0, 0, 2};
    tbl[10] = '{1, 0, 1, 1, 0, 0, 3};
    tbl[11] = '{1, 0, 1, 1, 0, 0, 4};
    tbl[12] = '{1, 0, 1, 1, 0, 0, 5};
    tbl[13] = '{1, 0, 1, 1, 0, 0, 6};
    tbl[14] = '{1, 0, 1, 1, 0, 0, 7};
    tbl[15] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[16] = '{1, 0, 1, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 1, 0, 1, 0, 0};
    tbl[18] = '{1, 1, 1, 0, 0, 0, 0};

    // Reset state, before any clock edge.
    #1;
    chk("reset_dut0", 32'(w_pk0), 32'(23'h000000));
    chk("reset_dut1", 32'(w_pk1), 32'({2'b11, 21'h0}));
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;

    // First line after release, including a pce hold.
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].p);
      chk($sformatf("tbl%0d_hs", i),  32'(hs0),  32'(tbl[i].hs));
      chk($sformatf("tbl%0d_vs", i),  32'(vs0),  32'(tbl[i].vs));
      chk($sformatf("tbl%0d_hen", i), 32'(hen0), 32'(tbl[i].hen));
      chk($sformatf("tbl%0d_ls", i),  32'(ls0),  32'(tbl[i].ls));
      chk($sformatf("tbl%0d_fs", i),  32'(fs0),  32'(tbl[i].fs));
      chk($sformatf("tbl%0d_x", i),   32'(x0),   32'(tbl[i].x));
    end

    // Random pce density, checked against the model every cycle.
    for (int blk = 0; blk < 5; blk++) begin
      case (blk)
        0: dens = 100;
        1: dens = 75;
        2: dens = 50;
        3: dens = 20;
        default: dens = 90;
      endcase
      for (int k = 0; k < 300; k++) step($urandom_range(0, 99) < dens);
    end

    // Full-frame statistics with pce held high.
    do_reset();
    fs_seen = 0; fs_a = -1; fs_b = -1; c_ls = 0; c_de = 0; c_vs = 0;
    for (int k = 0; k < 2 * HT * VT + 10; k++) begin
      step(1'b1);
      if (fs0) begin
        fs_seen++;
        if (fs_seen == 1) fs_a = k;
        if (fs_seen == 2) fs_b = k;
      end
      if (fs_seen == 1) begin
        c_ls += int'(ls0);
        c_de += int'(de0);
        c_vs += int'(vs0);
      end
    end
    chk("frame_period", 32'(fs_b - fs_a), 32'(HT * VT));
    chk("line_starts_per_frame", 32'(c_ls), 32'(VT));
    chk("de_per_frame", 32'(c_de), 32'(H_ACT * V_ACT));
    chk("vs_per_frame", 32'(c_vs), 32'(V_SW * HT));

    // Alternating pce: line period doubles, line_start stays one pclk wide.
    do_reset();
    ls_a = -1; ls_b = -1; ls_cnt = 0; c_hs = 0; prev_ls = 0; dbl = 0;
    for (int k = 0; k < 4 * HT + 4; k++) begin
      step(k % 2 == 0);
      if (ls0 && prev_ls) dbl = 1;
      prev_ls = ls0;
      if (ls0) begin
        ls_cnt++;
        if (ls_cnt == 1) ls_a = k;
        if (ls_cnt == 2) ls_b = k;
      end
      if (ls_cnt == 1) c_hs += int'(hs0);
    end
    chk("half_rate_line_period", 32'(ls_b - ls_a), 32'(2 * HT));
    chk("half_rate_ls_width", 32'(dbl), 32'(0));
    chk("half_rate_hs_width", 32'(c_hs), 32'(2 * H_SW));

    // Line and frame wrap on the same edge, then async reset mid-frame.
    for (int k = 0; k < HT * VT + 2; k++) step(1'b1);
    for (int k = 0; k < HT * VT && !((n % HT == 7) && ((n / HT) % VT == 4)); k++) step(1'b1);
    chk("midframe_reached", 32'(n % HT), 32'(7));
    do_reset();
    step(1'b1);
    chk("restart_fs", 32'(fs0), 32'(1));
    chk("restart_hs", 32'(hs0), 32'(1));
    for (int k = 0; k < 6; k++) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dst_gen.md
Name: dst_gen

Overview:
- Parametrised display scan-timing generator, successor to the fixed-polarity scan block.
- Produces sync, enable, pixel-coordinate and frame/line marker signals for the video output path.
- Adds a pixel-clock enable, programmable sync polarity, a registered output pipeline with configurable extra delay (to align with pixel-data latency), and active-area x/y coordinates.

Parameters:
- H_SW, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch
- H_ACT, 800, horizontal active pixels
- H_FP, 56, horizontal front porch
- V_SW, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch
- V_ACT, 600, vertical active lines
- V_FP, 37, vertical front porch
- HS_POL, 1, hs active level (1 = active-high, 0 = active-low)
- VS_POL, 1, vs active level
- DELAY, 0, extra pipeline stages on all outputs (0..15)
- CW, 12, counter and coordinate width

Ports:
- pclk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pce  in  1  pixel-count enable; counters advance only when 1
- hs  out  1  horizontal sync, polarity per HS_POL
- vs  out  1  vertical sync, polarity per VS_POL
- hen  out  1  horizontal active region
- ven  out  1  vertical active region
- de  out  1  hen & ven
- x  out  CW  active-area column, 0..H_ACT-1
- y  out  CW  active-area row, 0..V_ACT-1
- line_start  out  1  one-pclk pulse at start of each line
- frame_start  out  1  one-pclk pulse at start of each frame

Behaviour:

Counters:
- H_TOTAL = H_SW+H_BP+H_ACT+H_FP and V_TOTAL = V_SW+V_BP+V_ACT+V_FP. Elaboration fails if either exceeds 2^CW.
- h_cnt and v_cnt are CW bits wide and reset to 0.
- h_cnt advances by 1 on each pclk edge with pce=1, wrapping from H_TOTAL-1 to 0.
- v_cnt advances only on an edge where pce=1 and h_cnt=H_TOTAL-1, wrapping from V_TOTAL-1 to 0.
- With pce=0, both counters hold.

Region order per line and per frame: sync, back porch, active, front porch.

Decode (stage 0, combinational from the counters):
- hs_a = h_cnt < H_SW
- vs_a = v_cnt < V_SW
- hen = H_SW+H_BP <= h_cnt < H_SW+H_BP+H_ACT; ven is the vertical equivalent
- de = hen & ven
- x = h_cnt-(H_SW+H_BP) when hen, else 0; y = v_cnt-(V_SW+V_BP) when ven, else 0
- line_start = pce & (h_cnt==0)
- frame_start = pce & (h_cnt==0) & (v_cnt==0)

Pipeline:
- Stage 0 is registered into stage 1, followed by DELAY further register stages. All stages clock every pclk and are not gated by pce.
- Outputs come from the last stage. Latency from counter state to output is 1+DELAY pclk cycles for every signal; all outputs stay mutually aligned.
- Output hs = HS_POL ? hs_a : ~hs_a; vs likewise with VS_POL.

Reset:
- rst clears the counters and every pipeline stage immediately, without waiting for a clock edge.
- Output values during and after reset until the pipeline refills: hs=~HS_POL, vs=~VS_POL, hen=ven=de=0, x=y=0, line_start=frame_start=0.
- First clock edge after rst deasserts: stage 1 loads the decode of count (0,0), so hs and vs go active 1+DELAY edges after release.
- The frame_start pulse for count (0,0) also appears then if pce=1.

Boundary conditions:
- pce held low: outputs freeze at the current decode after the pipeline flushes; pulses deassert.
- pce asserted sparsely: each pulse lasts exactly one pclk, and line_start fires once per line.
- Line wrap and frame wrap on the same edge (h=H_TOTAL-1, v=V_TOTAL-1, pce=1): both counters go to 0.
- No other inputs exist, so no further simultaneous events need defining.

Test Plan:
1. Defaults, pce=1, release rst at edge 0 → hs high for edges 1..120, then period 1040; hen rises at edge 185 and stays high 800 cycles; ven low until line 29.
2. Run a full frame → frame_start pulses exactly 692640 cycles apart; vs high 6240 cycles; de high for 480000 cycles per frame; line_start fires 666 times.
3. Observe coordinates → first de cycle x=0, y=0; last de cycle x=799, y=599; x=0 whenever hen=0 and y=0 whenever ven=0.
4. pce toggling 1,0,1,0 → line period 2080 pclk; line_start is one-pclk wide, once per line; hs high 240 pclk.
5. DELAY=3, HS_POL=0, VS_POL=0 → every output lags the DELAY=0 instance by exactly 3 cycles; hs/vs are low during sync; hs/vs read 1 during reset.
6. Assert rst asynchronously mid-frame at h=500, v=300 → outputs reach reset values before the next pclk edge; after release, counting restarts at (0,0) and frame_start fires at edge 1.
